// File: rtl/prog_mem_arbiter.sv
// Program-memory read arbiter: round-robin multiplexing of per-fetcher read
// requests onto a smaller set of memory read channels, holding each response until released.
module prog_mem_arbiter #(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 16,
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned NUM_CHANNELS  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data
);

  localparam int unsigned IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {IDLE, WAITING, RELAYING} ch_state_t;

  ch_state_t               ch_state [NUM_CHANNELS];
  logic [IDX_BITS-1:0]     ch_owner [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] claimed;
  logic [IDX_BITS-1:0]     rr_ptr;

  logic [NUM_CONSUMERS-1:0] eligible;
  logic [NUM_CONSUMERS-1:0] taken;
  logic [NUM_CHANNELS-1:0]  grant_en;
  logic [IDX_BITS-1:0]      grant_idx  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     grant_addr [NUM_CHANNELS];
  logic [IDX_BITS-1:0]      rr_next;
  int unsigned              cand;

  assign eligible = consumer_read_valid & ~claimed;

  // Each idle channel takes the first eligible consumer at or after rr_ptr that
  // an earlier (lower-index) channel has not already taken on this edge.
  always_comb begin
    taken    = '0;
    grant_en = '0;
    rr_next  = rr_ptr;
    cand     = 0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      grant_idx[c]  = '0;
      grant_addr[c] = '0;
    end
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_state[c] == IDLE) begin
        for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
          cand = (32'(rr_ptr) + k) % NUM_CONSUMERS;
          if (!grant_en[c] && eligible[cand] && !taken[cand]) begin
            grant_en[c]   = 1'b1;
            grant_idx[c]  = IDX_BITS'(cand);
            grant_addr[c] = consumer_read_address[cand*ADDR_BITS +: ADDR_BITS];
            taken[cand]   = 1'b1;
            rr_next       = IDX_BITS'((cand + 1) % NUM_CONSUMERS);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        ch_state[c] <= IDLE;
        ch_owner[c] <= '0;
      end
      claimed             <= '0;
      rr_ptr              <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
      mem_read_valid      <= '0;
      mem_read_address    <= '0;
    end else begin
      rr_ptr <= rr_next;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        case (ch_state[c])
          IDLE: begin
            if (grant_en[c]) begin
              ch_state[c]                                  <= WAITING;
              ch_owner[c]                                  <= grant_idx[c];
              claimed[grant_idx[c]]                        <= 1'b1;
              mem_read_valid[c]                            <= 1'b1;
              mem_read_address[c*ADDR_BITS +: ADDR_BITS]   <= grant_addr[c];
            end
          end
          WAITING: begin
            if (mem_read_ready[c]) begin
              ch_state[c]                  <= RELAYING;
              mem_read_valid[c]            <= 1'b0;
              consumer_read_ready[ch_owner[c]] <= 1'b1;
              consumer_read_data[32'(ch_owner[c])*DATA_BITS +: DATA_BITS] <=
                mem_read_data[c*DATA_BITS +: DATA_BITS];
            end
          end
          RELAYING: begin
            if (!consumer_read_valid[ch_owner[c]]) begin
              ch_state[c]                      <= IDLE;
              consumer_read_ready[ch_owner[c]] <= 1'b0;
              claimed[ch_owner[c]]             <= 1'b0;
            end
          end
          default: ch_state[c] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Bench for prog_mem_arbiter: one-channel and two-channel instances share consumer stimulus;
// a transaction-level model is compared every cycle, plus directed literal checks.
module tb_prog_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  cvalid;
  logic [31:0] caddr;

  logic [3:0]  crdy1, crdy2;
  logic [63:0] cdata1, cdata2;
  logic [0:0]  mv1;
  logic [7:0]  ma1;
  logic [0:0]  mrdy1;
  logic [15:0] md1;
  logic [1:0]  mv2;
  logic [15:0] ma2;
  logic [1:0]  mrdy2;
  logic [31:0] md2;

  logic [15:0] mem [256];
  bit          auto1, auto2;
  int          n_cmp, n_bad;

  assign md1 = mem[ma1];
  assign md2 = {mem[ma2[15:8]], mem[ma2[7:0]]};

  prog_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(cvalid), .consumer_read_address(caddr),
    .consumer_read_ready(crdy1), .consumer_read_data(cdata1),
    .mem_read_valid(mv1), .mem_read_address(ma1),
    .mem_read_ready(mrdy1), .mem_read_data(md1)
  );

  prog_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(cvalid), .consumer_read_address(caddr),
    .consumer_read_ready(crdy2), .consumer_read_data(cdata2),
    .mem_read_valid(mv2), .mem_read_address(ma2),
    .mem_read_ready(mrdy2), .mem_read_data(md2)
  );

  // Transaction model: per instance d, each channel has an owning consumer
  // (-1 = free) and a flag saying whether its word has been delivered.
  int          owner   [2][2];
  bit          deliv   [2][2];
  logic [7:0]  maddr_m [2][2];
  int          rr_m    [2];
  logic [15:0] data_m  [2][4];
  bit          started;

  task automatic model_step();
    int gown [2];
    bit busy [4];
    int pick, rrn;
    logic [1:0] rdy;
    for (int d = 0; d < 2; d++) begin
      rdy = (d == 0) ? {1'b0, mrdy1} : mrdy2;
      if (!reset) begin
        started = 1'b1;
        rr_m[d] = 0;
        for (int c = 0; c < 2; c++) begin
          owner[d][c] = -1; deliv[d][c] = 1'b0; maddr_m[d][c] = '0;
        end
        for (int i = 0; i < 4; i++) data_m[d][i] = '0;
      end else begin
        for (int i = 0; i < 4; i++) busy[i] = 1'b0;
        for (int c = 0; c <= d; c++) if (owner[d][c] >= 0) busy[owner[d][c]] = 1'b1;
        gown[0] = -1; gown[1] = -1;
        rrn = rr_m[d];
        for (int c = 0; c <= d; c++) begin
          if (owner[d][c] < 0) begin
            for (int k = 0; k < 4; k++) begin
              pick = (rr_m[d] + k) % 4;
              if (gown[c] < 0 && cvalid[pick] && !busy[pick]) begin
                gown[c] = pick; busy[pick] = 1'b1; rrn = (pick + 1) % 4;
              end
            end
          end
        end
        for (int c = 0; c <= d; c++) begin
          if (owner[d][c] >= 0) begin
            if (!deliv[d][c]) begin
              if (rdy[c]) begin
                deliv[d][c] = 1'b1;
                data_m[d][owner[d][c]] = mem[maddr_m[d][c]];
              end
            end else if (!cvalid[owner[d][c]]) begin
              owner[d][c] = -1; deliv[d][c] = 1'b0;
            end
          end
        end
        for (int c = 0; c <= d; c++) begin
          if (gown[c] >= 0) begin
            owner[d][c] = gown[c]; deliv[d][c] = 1'b0;
            maddr_m[d][c] = caddr[gown[c]*8 +: 8];
          end
        end
        rr_m[d] = rrn;
      end
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [1:0]  emv;
    logic [15:0] ema;
    logic [3:0]  erdy;
    logic [63:0] edata;
    for (int d = 0; d < 2; d++) begin
      emv = '0; ema = '0; erdy = '0; edata = '0;
      for (int c = 0; c <= d; c++) begin
        emv[c] = (owner[d][c] >= 0) && !deliv[d][c];
        ema[c*8 +: 8] = maddr_m[d][c];
        if (owner[d][c] >= 0 && deliv[d][c]) erdy[owner[d][c]] = 1'b1;
      end
      for (int i = 0; i < 4; i++) edata[i*16 +: 16] = data_m[d][i];
      if (d == 0) begin
        chk("ch1.mem_valid", 64'(mv1), 64'(emv));
        chk("ch1.mem_addr", 64'(ma1), 64'(ema));
        chk("ch1.cons_ready", 64'(crdy1), 64'(erdy));
        chk("ch1.cons_data", cdata1, edata);
      end else begin
        chk("ch2.mem_valid", 64'(mv2), 64'(emv));
        chk("ch2.mem_addr", 64'(ma2), 64'(ema));
        chk("ch2.cons_ready", 64'(crdy2), 64'(erdy));
        chk("ch2.cons_data", cdata2, edata);
      end
    end
  endtask

  // Inputs are final before the model step; outputs are sampled on the falling edge.
  task automatic tick();
    if (auto1) mrdy1 = mv1;
    if (auto2) mrdy2 = mv2;
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (started) compare_all();
  endtask

  task automatic reset_dut();
    reset = 1'b0; cvalid = '0; caddr = '0; mrdy1 = '0; mrdy2 = '0;
    auto1 = 1'b0; auto2 = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  int          order [$];
  logic [15:0] exp_c [4] = '{16'h4A4A, 16'h4B4B, 16'hBEEF, 16'h4949};

  initial begin
    n_cmp = 0; n_bad = 0; started = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'((i * 257) ^ 16'h5A5A);
    mem[8'h12] = 16'hBEEF;
    @(negedge clk);

    // Single consumer, memory ready three cycles after the request appears
    reset_dut();
    cvalid = 4'b0001; caddr[7:0] = 8'h12;
    tick(); chk("single.t1_valid", 64'(mv1), 1); chk("single.t1_addr", 64'(ma1), 64'h12);
    tick(); chk("single.t2_valid", 64'(mv1), 1);
    tick(); chk("single.t3_valid", 64'(mv1), 1);
    mrdy1 = 1'b1;
    tick(); chk("single.t4_ready", 64'(crdy1), 64'b0001); chk("single.t4_data", 64'(cdata1[15:0]), 64'hBEEF);
    chk("single.t4_memvalid", 64'(mv1), 0);
    mrdy1 = 1'b0;
    tick(); chk("single.t5_ready", 64'(crdy1), 64'b0001);
    cvalid = 4'b0000;
    tick(); chk("single.t6_ready", 64'(crdy1), 0);

    // Contention on one channel with one-cycle memory
    reset_dut();
    auto1 = 1'b1; auto2 = 1'b1;
    cvalid = 4'b1111; caddr = {8'h13, 8'h12, 8'h11, 8'h10};
    order.delete();
    for (int t = 0; t < 80 && order.size() < 4; t++) begin
      tick();
      for (int i = 0; i < 4; i++)
        if (crdy1[i] && cvalid[i]) begin
          order.push_back(i);
          chk("contention.data", 64'(cdata1[i*16 +: 16]), 64'(exp_c[i]));
          cvalid[i] = 1'b0;
        end
    end
    chk("contention.served", 64'(order.size()), 4);
    for (int k = 0; k < order.size(); k++) chk("contention.order", 64'(order[k]), 64'(k));
    // Pointer has wrapped to 0, so consumer 1 beats consumer 3
    tick(); tick();
    cvalid = 4'b1010;
    order.delete();
    for (int t = 0; t < 40 && order.size() < 2; t++) begin
      tick();
      for (int i = 0; i < 4; i++)
        if (crdy1[i] && cvalid[i]) begin order.push_back(i); cvalid[i] = 1'b0; end
    end
    chk("rr_wrap.served", 64'(order.size()), 2);
    if (order.size() == 2) begin
      chk("rr_wrap.first", 64'(order[0]), 1);
      chk("rr_wrap.second", 64'(order[1]), 3);
    end

    // Fairness between consumers 0 and 2 with the pointer at 1
    reset_dut();
    auto1 = 1'b1; auto2 = 1'b1;
    cvalid = 4'b0001; caddr = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int t = 0; t < 20 && cvalid[0]; t++) begin
      tick();
      if (crdy1[0]) cvalid[0] = 1'b0;
    end
    tick(); tick();
    order.delete();
    for (int t = 0; t < 100 && order.size() < 4; t++) begin
      tick();
      for (int i = 0; i < 4; i += 2) begin
        if (!cvalid[i]) cvalid[i] = 1'b1;
        else if (crdy1[i]) begin order.push_back(i); cvalid[i] = 1'b0; end
      end
    end
    chk("fair.served", 64'(order.size()), 4);
    for (int k = 0; k < order.size(); k++) chk("fair.order", 64'(order[k]), (k % 2 == 0) ? 2 : 0);

    // Two channels, completions out of order
    reset_dut();
    cvalid = 4'b1010; caddr = {8'h23, 8'h00, 8'h21, 8'h00};
    tick(); chk("par.t1_valid", 64'(mv2), 64'b11); chk("par.t1_addr", 64'(ma2), 64'h2321);
    tick();
    mrdy2 = 2'b10;
    tick(); chk("par.t3_ready", 64'(crdy2), 64'b1000); chk("par.t3_valid", 64'(mv2), 64'b01);
    chk("par.t3_data3", 64'(cdata2[63:48]), 64'h7979);
    mrdy2 = 2'b01;
    tick(); chk("par.t4_ready", 64'(crdy2), 64'b1010); chk("par.t4_data1", 64'(cdata2[31:16]), 64'h7B7B);
    mrdy2 = 2'b00; cvalid = 4'b0000;
    tick(); tick(); chk("par.release", 64'(crdy2), 0);

    // Valid dropped while waiting for memory
    reset_dut();
    cvalid = 4'b0001; caddr[7:0] = 8'h12;
    tick(); tick();
    cvalid = 4'b0000;
    tick();
    mrdy1 = 1'b1;
    tick(); chk("drop.t4_ready", 64'(crdy1), 64'b0001); chk("drop.t4_data", 64'(cdata1[15:0]), 64'hBEEF);
    mrdy1 = 1'b0;
    cvalid = 4'b0010; caddr[15:8] = 8'h20;
    tick(); chk("drop.t5_ready", 64'(crdy1), 0); chk("drop.t5_valid", 64'(mv1), 0);
    tick(); chk("drop.t6_reuse", 64'(mv1), 1); chk("drop.t6_addr", 64'(ma1), 64'h20);

    // Reset while waiting, late memory ready afterwards
    reset_dut();
    cvalid = 4'b0001; caddr[7:0] = 8'h33;
    tick(); tick();
    reset = 1'b0; cvalid = 4'b0000;
    tick();
    chk("rst.t3_valid", 64'(mv1), 0); chk("rst.t3_addr", 64'(ma1), 0);
    chk("rst.t3_ready", 64'(crdy1), 0); chk("rst.t3_data", cdata1, 0);
    reset = 1'b1; mrdy1 = 1'b1;
    tick(); chk("rst.late_ready", 64'(crdy1), 0); chk("rst.late_valid", 64'(mv1), 0);
    mrdy1 = 1'b0; cvalid = 4'b0100; caddr[23:16] = 8'h44;
    tick(); chk("rst.new_valid", 64'(mv1), 1); chk("rst.new_addr", 64'(ma1), 64'h44);
    mrdy1 = 1'b1;
    tick(); chk("rst.new_ready", 64'(crdy1), 64'b0100); chk("rst.new_data", 64'(cdata1[47:32]), 64'h1E1E);
    mrdy1 = 1'b0; cvalid = 4'b0000;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
